// File: rtl/conv_pool_sched.sv
// 2x2 max-pool sequencer: reads four source words per output pixel, keeps a
// running max, and writes one (optionally ceiling-rounded) result per window.
module conv_pool_sched #(
  parameter logic [2:0] SRC_SEL  = 3'b001,
  parameter logic [2:0] DST_SEL  = 3'b011,
  parameter bit         ROUND_UP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    WR   = 3'd5,
    FIN  = 3'd6
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_k, w_k_nxt;
  logic [19:0] r_max, w_max_nxt, w_max_upd;
  logic        w_stalled;

  logic        r_busy, r_done, r_crd, r_cwr;
  logic [2:0]  r_csel;
  logic [11:0] r_caddr_rd, r_caddr_wr;
  logic [19:0] r_cdata_wr;

  logic        w_busy_nxt, w_done_nxt, w_crd_nxt, w_cwr_nxt;
  logic [2:0]  w_csel_nxt;
  logic [11:0] w_caddr_rd_nxt, w_caddr_wr_nxt;
  logic [19:0] w_cdata_wr_nxt;

  // Ceiling to the next integer in 4.16 format, saturating at the top code.
  function automatic logic [19:0] pool_round(input logic [19:0] m);
    if (!ROUND_UP || m[15:0] == 16'h0000) begin
      return m;
    end else if (m[19:16] == 4'hF) begin
      return 20'hFFFFF;
    end else begin
      return {m[19:16] + 4'h1, 16'h0000};
    end
  endfunction

  // Window address: row 2r (+1 for hi), column 2c (+1 for lo), row pitch 64.
  function automatic logic [11:0] rd_addr(input logic [9:0] k, input logic hi, input logic lo);
    return {k[9:5], hi, k[4:0], lo};
  endfunction

  assign w_stalled = stall && (r_state != IDLE) && (r_state != FIN);
  assign w_max_upd = (cdata_rd > r_max) ? cdata_rd : r_max;

  // Sequencer next state, output index and running max.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_max_nxt   = r_max;
    if (!w_stalled) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt = RD0;
            w_k_nxt     = 10'd0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        RD0: begin
          w_max_nxt   = cdata_rd;
          w_state_nxt = RD1;
        end
        RD1: begin
          w_max_nxt   = w_max_upd;
          w_state_nxt = RD2;
        end
        RD2: begin
          w_max_nxt   = w_max_upd;
          w_state_nxt = RD3;
        end
        RD3: begin
          w_max_nxt   = w_max_upd;
          w_state_nxt = WR;
        end
        WR: begin
          if (r_k == 10'd1023) begin
            w_state_nxt = FIN;
          end else begin
            w_k_nxt     = r_k + 10'd1;
            w_state_nxt = RD0;
          end
        end
        FIN:     w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Output register inputs derived from the state being entered.
  always_comb begin
    w_busy_nxt     = (w_state_nxt != IDLE);
    w_done_nxt     = (w_state_nxt == FIN);
    w_crd_nxt      = 1'b0;
    w_cwr_nxt      = 1'b0;
    w_csel_nxt     = 3'b000;
    w_caddr_rd_nxt = r_caddr_rd;
    w_caddr_wr_nxt = r_caddr_wr;
    w_cdata_wr_nxt = r_cdata_wr;
    case (w_state_nxt)
      RD0: begin
        w_crd_nxt      = 1'b1;
        w_csel_nxt     = SRC_SEL;
        w_caddr_rd_nxt = rd_addr(w_k_nxt, 1'b0, 1'b0);
      end
      RD1: begin
        w_crd_nxt      = 1'b1;
        w_csel_nxt     = SRC_SEL;
        w_caddr_rd_nxt = rd_addr(w_k_nxt, 1'b0, 1'b1);
      end
      RD2: begin
        w_crd_nxt      = 1'b1;
        w_csel_nxt     = SRC_SEL;
        w_caddr_rd_nxt = rd_addr(w_k_nxt, 1'b1, 1'b0);
      end
      RD3: begin
        w_crd_nxt      = 1'b1;
        w_csel_nxt     = SRC_SEL;
        w_caddr_rd_nxt = rd_addr(w_k_nxt, 1'b1, 1'b1);
      end
      WR: begin
        w_cwr_nxt      = 1'b1;
        w_csel_nxt     = DST_SEL;
        w_caddr_wr_nxt = {2'b00, w_k_nxt};
        w_cdata_wr_nxt = pool_round(w_max_nxt);
      end
      default: w_crd_nxt = 1'b0;
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_k        <= 10'd0;
      r_max      <= 20'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_csel     <= 3'b000;
      r_caddr_rd <= 12'd0;
      r_caddr_wr <= 12'd0;
      r_cdata_wr <= 20'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_max      <= w_max_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_crd      <= w_crd_nxt;
      r_cwr      <= w_cwr_nxt;
      r_csel     <= w_csel_nxt;
      r_caddr_rd <= w_caddr_rd_nxt;
      r_caddr_wr <= w_caddr_wr_nxt;
      r_cdata_wr <= w_cdata_wr_nxt;
    end
  end

  // A stall lends the port away in the same cycle, so strobes and select are masked.
  assign busy     = r_busy;
  assign done     = r_done;
  assign crd      = r_crd & ~w_stalled;
  assign cwr      = r_cwr & ~w_stalled;
  assign csel     = w_stalled ? 3'b000 : r_csel;
  assign caddr_rd = r_caddr_rd;
  assign caddr_wr = r_caddr_wr;
  assign cdata_wr = r_cdata_wr;

endmodule
